pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk_i  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have port rst_n_i  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port d_valid_i  in  1  decode stage holds a real instruction.
REQ-004 SHALL have port d_icode_i  in  4  decode-stage icode, encoded with the `I* macros from define.v.
REQ-005 SHALL have ports d_srcA_i, d_srcB_i, d_dstE_i, d_dstM_i  in  4 each  decode register IDs, with 4'hF meaning none.
REQ-006 SHALL have port e_mispredict_i  in  1  execute reports that the jXX in E was mispredicted.
REQ-007 SHALL have ports f_stall_o, d_stall_o  out  1 each  hold the F and D pipeline registers.
REQ-008 SHALL have ports d_bubble_o, e_bubble_o  out  1 each  insert a NOP into D or E next cycle.
REQ-009 SHALL have ports fwdA_sel_o, fwdB_sel_o  out  3 each  operand source select, coded 0=regfile 1=e_valE 2=m_valM 3=m_valE 4=w_valM 5=w_valE 6=valP (A only).
REQ-010 SHALL have port halted_o  out  1  sticky: the pipeline is halted.

Function
REQ-011 SHALL keep a 3-entry in-flight scoreboard for stages E, M and W; each entry holds {valid, icode[3:0], dstE[3:0], dstM[3:0]}.
REQ-012 Each cycle, unless halted, the scoreboard SHALL advance as follows: W<=M, M<=E.
REQ-013 Each cycle, unless halted, E SHALL load the decode fields; E SHALL instead load an empty entry (valid=0, icode=INOP, dst=F) when e_bubble_o=1 or d_valid_i=0.
REQ-014 Load-use hazard SHALL be detected when E.valid, E.icode is MRMOVQ or POPQ, E.dstM!=F, and E.dstM equals d_srcA_i or d_srcB_i.
REQ-015 Return hazard SHALL be detected when d_icode_i, E.icode or M.icode equals IRET, with each stage entry qualified by its valid bit.
REQ-016 Mispredict SHALL be detected when e_mispredict_i=1, E.valid=1 and E.icode=IJXX; e_mispredict_i SHALL be ignored otherwise.
REQ-017 On load-use alone, outputs SHALL be: f_stall=1, d_stall=1, e_bubble=1, d_bubble=0.
REQ-018 On mispredict, outputs SHALL be: d_bubble=1, e_bubble=1, stalls=0; this overrides the return hazard.
REQ-019 On return hazard without load-use or mispredict, outputs SHALL be: f_stall=1, d_bubble=1.
REQ-020 On load-use together with return hazard, the REQ-017 outputs SHALL apply (d_bubble=0).
REQ-021 d_stall_o and d_bubble_o SHALL never both be 1 in the same cycle.
REQ-022 fwdA_sel_o SHALL be 6 when d_icode_i is ICALL or IJXX.
REQ-023 Otherwise, fwdA_sel_o and fwdB_sel_o SHALL be 0 when the source is F.
REQ-024 Otherwise, the forward select SHALL be the first match in this priority order: E.dstE=1, M.dstM=2, M.dstE=3, W.dstM=4, W.dstE=5, else 0; only valid entries with dst!=F SHALL match.
REQ-025 All control and select outputs SHALL be combinational from the inputs and the scoreboard, with zero-cycle latency.
REQ-026 halted_o SHALL set on the edge where an entry with W.valid=1 and W.icode=IHALT is present.
REQ-027 Once halted_o=1, f_stall and d_stall SHALL be held at 1, the bubbles at 0, and the scoreboard frozen.
REQ-028 Only reset SHALL clear halted_o.

Reset
REQ-029 While rst_n_i=0, all scoreboard entries SHALL be empty and halted_o=0, asynchronously.
REQ-030 While rst_n_i=0, all stall and bubble outputs SHALL be 0 and the forward selects SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard every in-flight entry, with no residual hazard after release.

Verification
REQ-032 Load-use test: issue MRMOVQ dstM=3, then the next D has srcA=3 -> in that cycle f_stall=d_stall=e_bubble=1; the cycle after, fwdA_sel=2 and there are no stalls.
REQ-033 Forward-priority test: OPQ dstE=2 in E and IRMOVQ dstE=2 in W, with D srcB=2 -> fwdB_sel=1; with srcB=F -> fwdB_sel=0.
REQ-034 RET test: RET in D -> f_stall=1 and d_bubble=1 for 3 consecutive cycles (D, E, M), then both drop to 0.
REQ-035 Mispredict test: JXX in E with e_mispredict_i=1 while a load-use condition is also true -> d_bubble=e_bubble=1, f_stall=d_stall=0.
REQ-036 Halt test: HALT issued -> halted_o=1 three edges later and stays 1.
REQ-037 Reset-release test: asserting rst_n_i=0 mid-operation -> halted_o=0 and all stall/bubble outputs 0 immediately.

Source files
------------

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- hazard and forwarding controller for a 5-stage Y86-64 pipeline.
//
// Tracks the instructions in E, M and W in a small scoreboard. From that state
// and the decode-stage fields it produces combinational stall, bubble and
// operand-forwarding controls, plus a sticky halt flag.
//
// Ports
//   clk_i            sole clock, rising edge
//   rst_n_i          asynchronous active-low reset
//   d_valid_i        decode stage holds a real instruction
//   d_icode_i        decode-stage icode
//   d_srcA_i/B_i     decode source register IDs (4'hF = none)
//   d_dstE_i/M_i     decode destination register IDs (4'hF = none)
//   e_mispredict_i   execute reports that the jXX in E was mispredicted
//   f_stall_o        hold the F pipeline register
//   d_stall_o        hold the D pipeline register
//   d_bubble_o       insert a NOP into D next cycle
//   e_bubble_o       insert a NOP into E next cycle
//   fwdA_sel_o       operand A source: 0 rf, 1 e_valE, 2 m_valM, 3 m_valE,
//                    4 w_valM, 5 w_valE, 6 valP
//   fwdB_sel_o       operand B source, same coding without 6
//   halted_o         sticky halted flag
// -----------------------------------------------------------------------------
module pipe_ctrl (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       d_valid_i,
    input  logic [3:0] d_icode_i,
    input  logic [3:0] d_srcA_i,
    input  logic [3:0] d_srcB_i,
    input  logic [3:0] d_dstE_i,
    input  logic [3:0] d_dstM_i,
    input  logic       e_mispredict_i,
    output logic       f_stall_o,
    output logic       d_stall_o,
    output logic       d_bubble_o,
    output logic       e_bubble_o,
    output logic [2:0] fwdA_sel_o,
    output logic [2:0] fwdB_sel_o,
    output logic       halted_o
);

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] REG_NONE = 4'hF;

    typedef struct packed {
        logic       valid;
        logic [3:0] icode;
        logic [3:0] dste;
        logic [3:0] dstm;
    } sb_entry_t;

    localparam sb_entry_t EMPTY_ENTRY = '{valid: 1'b0, icode: I_NOP,
                                          dste: REG_NONE, dstm: REG_NONE};

    sb_entry_t e_r;
    sb_entry_t m_r;
    sb_entry_t w_r;
    logic      halted_r;

    logic       load_use_s;
    logic       ret_hazard_s;
    logic       mispredict_s;
    logic       f_stall_s;
    logic       d_stall_s;
    logic       d_bubble_s;
    logic       e_bubble_s;
    logic [2:0] fwd_a_s;
    logic [2:0] fwd_b_s;

    // First matching in-flight producer, nearest stage first; 0 = register file.
    function automatic logic [2:0] fwd_sel(input logic [3:0] src,
                                           input sb_entry_t e,
                                           input sb_entry_t m,
                                           input sb_entry_t w);
        logic [2:0] sel;
        if (src == REG_NONE) begin
            sel = 3'd0;
        end else if (e.valid && (e.dste == src)) begin
            sel = 3'd1;
        end else if (m.valid && (m.dstm == src)) begin
            sel = 3'd2;
        end else if (m.valid && (m.dste == src)) begin
            sel = 3'd3;
        end else if (w.valid && (w.dstm == src)) begin
            sel = 3'd4;
        end else if (w.valid && (w.dste == src)) begin
            sel = 3'd5;
        end else begin
            sel = 3'd0;
        end
        return sel;
    endfunction

    // Hazard detection from the decode fields and the E/M scoreboard entries.
    always_comb begin
        load_use_s   = e_r.valid
                     && ((e_r.icode == I_MRMOVQ) || (e_r.icode == I_POPQ))
                     && (e_r.dstm != REG_NONE)
                     && ((e_r.dstm == d_srcA_i) || (e_r.dstm == d_srcB_i));
        ret_hazard_s = (d_icode_i == I_RET)
                     || (e_r.valid && (e_r.icode == I_RET))
                     || (m_r.valid && (m_r.icode == I_RET));
        mispredict_s = e_mispredict_i && e_r.valid && (e_r.icode == I_JXX);
    end

    // Stall/bubble priority: halt, then mispredict, then load-use, then return.
    always_comb begin
        f_stall_s  = 1'b0;
        d_stall_s  = 1'b0;
        d_bubble_s = 1'b0;
        e_bubble_s = 1'b0;
        if (!rst_n_i) begin
            f_stall_s = 1'b0;
        end else if (halted_r) begin
            f_stall_s = 1'b1;
            d_stall_s = 1'b1;
        end else if (mispredict_s) begin
            d_bubble_s = 1'b1;
            e_bubble_s = 1'b1;
        end else if (load_use_s) begin
            f_stall_s  = 1'b1;
            d_stall_s  = 1'b1;
            e_bubble_s = 1'b1;
        end else if (ret_hazard_s) begin
            f_stall_s  = 1'b1;
            d_bubble_s = 1'b1;
        end else begin
            f_stall_s = 1'b0;
        end
    end

    // Operand source selection; call/jump take valP on the A port.
    always_comb begin
        fwd_a_s = 3'd0;
        fwd_b_s = 3'd0;
        if (!rst_n_i) begin
            fwd_a_s = 3'd0;
            fwd_b_s = 3'd0;
        end else begin
            if ((d_icode_i == I_CALL) || (d_icode_i == I_JXX)) begin
                fwd_a_s = 3'd6;
            end else begin
                fwd_a_s = fwd_sel(d_srcA_i, e_r, m_r, w_r);
            end
            fwd_b_s = fwd_sel(d_srcB_i, e_r, m_r, w_r);
        end
    end

    // Scoreboard advance and sticky halt; everything freezes once halted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            e_r      <= EMPTY_ENTRY;
            m_r      <= EMPTY_ENTRY;
            w_r      <= EMPTY_ENTRY;
            halted_r <= 1'b0;
        end else begin
            if (w_r.valid && (w_r.icode == I_HALT)) begin
                halted_r <= 1'b1;
            end else begin
                halted_r <= halted_r;
            end
            if (!halted_r) begin
                w_r <= m_r;
                m_r <= e_r;
                if (e_bubble_s || !d_valid_i) begin
                    e_r <= EMPTY_ENTRY;
                end else begin
                    e_r <= '{valid: 1'b1, icode: d_icode_i,
                             dste: d_dstE_i, dstm: d_dstM_i};
                end
            end else begin
                w_r <= w_r;
                m_r <= m_r;
                e_r <= e_r;
            end
        end
    end

    assign f_stall_o  = f_stall_s;
    assign d_stall_o  = d_stall_s;
    assign d_bubble_o = d_bubble_s;
    assign e_bubble_o = e_bubble_s;
    assign fwdA_sel_o = fwd_a_s;
    assign fwdB_sel_o = fwd_b_s;
    assign halted_o   = halted_r;

endmodule
